// File: rtl/tone_pkg.sv
// Shared constants for the tone generator: default clock, divider width,
// frequency/divisor widths, FSM state encoding and two small BCD helpers.
package tone_pkg;

   localparam int CLK_HZ_DEFAULT = 100_000_000;
   // Width of the CLK_HZ/2 dividend, the quotient and the half-period counter.
   localparam int DIV_W          = $clog2(CLK_HZ_DEFAULT / 2);
   localparam int FREQ_W         = 14;
   localparam int DVSR_W         = 15;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_DIVIDE  = 2'd2;
   localparam logic [1:0] ST_APPLY   = 2'd3;

   // acc*10 + digit, built from shifts; never exceeds 9999 for legal digits.
   function automatic logic [FREQ_W-1:0] bcd_mac(input logic [FREQ_W-1:0] acc,
                                                 input logic [3:0]        digit);
      logic [FREQ_W+3:0] wide;
      wide = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {{FREQ_W{1'b0}}, digit};
      return wide[FREQ_W-1:0];
   endfunction

   function automatic logic bad_digit(input logic [3:0] digit);
      return digit > 4'd9;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a division (ignored while busy); the first quotient
//                 bit is produced on the start edge itself
//   dividend    : DIV_W-bit dividend, sampled on start
//   divisor     : DVSR_W-bit divisor, sampled on start (must be non-zero)
//   busy        : high while the remaining quotient bits are produced
//   done        : one-cycle pulse; quotient is valid from this cycle on
//   quotient    : DIV_W-bit result, held until the next start
module seq_divider
   import tone_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DIV_W-1:0]  dividend,
   input  logic [DVSR_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DIV_W-1:0]  quotient
);

   localparam int CNT_W = $clog2(DIV_W + 1);

   logic              load_op;
   logic [DVSR_W-1:0] rem_q;
   logic [DVSR_W-1:0] rem_src;
   logic [DVSR_W-1:0] rem_next;
   logic [DVSR_W-1:0] dvsr_q;
   logic [DVSR_W-1:0] dvsr_src;
   logic [DIV_W-1:0]  quo_q;
   logic [DIV_W-1:0]  quo_src;
   logic [DIV_W-1:0]  quo_next;
   logic [DVSR_W:0]   shifted;
   logic              fits;
   logic [CNT_W-1:0]  cnt_q;

   assign load_op  = start && !busy;
   assign rem_src  = load_op ? '0       : rem_q;
   assign quo_src  = load_op ? dividend : quo_q;
   assign dvsr_src = load_op ? divisor  : dvsr_q;

   // The remainder stays below the divisor, so it fits in DVSR_W bits.
   assign shifted  = {rem_src, quo_src[DIV_W-1]};
   assign fits     = shifted >= {1'b0, dvsr_src};
   assign rem_next = fits ? DVSR_W'(shifted - {1'b0, dvsr_src}) : shifted[DVSR_W-1:0];
   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   assign quo_next = {quo_src[DIV_W-2:0], fits};
   assign quotient = quo_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvsr_q <= '0;
      end else begin
         done <= 1'b0;
         if (load_op) begin
            rem_q  <= rem_next;
            quo_q  <= quo_next;
            dvsr_q <= divisor;
            cnt_q  <= CNT_W'(DIV_W - 1);
            busy   <= 1'b1;
         end else if (busy) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator with a BCD frequency load interface.
//   clk, reset        : system clock, synchronous active-high reset
//   load              : latch the four BCD digits (accepted only when idle)
//   *_Data            : BCD digits of the requested frequency in Hz
//   enable            : tone gate; low holds tone_out and the counter at 0
//   tone_out          : square wave, half-period floor(CLK_HZ/(2*freq)) cycles
//   busy              : high whenever the FSM is not idle
//   done / error      : one-cycle pulses for an applied / rejected load
//   freq_hz           : active frequency in binary
//
// state   | meaning
// IDLE    | waiting for load; digits checked here
// CONVERT | BCD -> binary, one digit per cycle, MSD first (4 cycles)
// DIVIDE  | half = (CLK_HZ/2) / freq in seq_divider (DIV_W cycles)
// APPLY   | publish freq_hz and the new half-period, pulse done
module tone_generator
   import tone_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEFAULT
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [3:0]        Thousands_Data,
   input  logic [3:0]        Hundreds_Data,
   input  logic [3:0]        Tens_Data,
   input  logic [3:0]        Ones_Data,
   input  logic              enable,
   output logic              tone_out,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [FREQ_W-1:0] freq_hz
);

   localparam logic [DIV_W-1:0] HALF_CLK = DIV_W'(CLK_HZ / 2);

   logic [1:0]        state_q;
   logic [3:0][3:0]   digits_q;
   logic [1:0]        digit_idx_q;
   logic [FREQ_W-1:0] acc_q;
   logic [FREQ_W-1:0] acc_next;
   logic              digits_bad;
   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [DIV_W-1:0]  quotient;
   logic [DIV_W-1:0]  half_new;
   logic              apply;
   logic [DIV_W-1:0]  active_half_q;
   logic [DIV_W-1:0]  pending_half_q;
   logic [DIV_W-1:0]  pending_eff;
   logic [DIV_W-1:0]  count_q;
   logic              tone_q;

   assign acc_next   = bcd_mac(acc_q, digits_q[2'd3 - digit_idx_q]);
   assign digits_bad = bad_digit(Thousands_Data) | bad_digit(Hundreds_Data) |
                       bad_digit(Tens_Data)      | bad_digit(Ones_Data);

   // Divider launches on the last CONVERT edge using the final value directly.
   assign div_start  = (state_q == ST_CONVERT) && (digit_idx_q == 2'd3) && (acc_next != '0);
   assign half_new   = (acc_q == '0) ? '0 : quotient;
   assign apply      = (state_q == ST_APPLY);
   assign pending_eff = apply ? half_new : pending_half_q;

   assign busy     = (state_q != ST_IDLE);
   assign tone_out = tone_q;

   seq_divider u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (HALF_CLK),
      .divisor  ({1'b0, acc_next}),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quotient)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         digits_q    <= '0;
         digit_idx_q <= '0;
         acc_q       <= '0;
         freq_hz     <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load) begin
                  if (digits_bad) begin
                     error <= 1'b1;
                  end else begin
                     digits_q    <= {Thousands_Data, Hundreds_Data, Tens_Data, Ones_Data};
                     acc_q       <= '0;
                     digit_idx_q <= '0;
                     state_q     <= ST_CONVERT;
                  end
               end
            end
            ST_CONVERT: begin
               acc_q       <= acc_next;
               digit_idx_q <= digit_idx_q + 2'd1;
               if (digit_idx_q == 2'd3) begin
                  state_q <= (acc_next == '0) ? ST_APPLY : ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               if (div_done && !div_busy) begin
                  state_q <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               freq_hz <= acc_q;
               done    <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // A new half-period normally waits for the next toggle so the running
   // half-period finishes with the old length; from or to silence it takes
   // effect at once. While gated off there is no half-period in progress,
   // so any pending value is adopted immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_half_q  <= '0;
         pending_half_q <= '0;
         count_q        <= '0;
         tone_q         <= 1'b0;
      end else begin
         if (apply) begin
            pending_half_q <= half_new;
         end
         if (apply && ((active_half_q == '0) || (half_new == '0))) begin
            active_half_q <= half_new;
            count_q       <= '0;
            tone_q        <= 1'b0;
         end else if (!enable || (active_half_q == '0)) begin
            active_half_q <= pending_eff;
            count_q       <= '0;
            tone_q        <= 1'b0;
         end else if (count_q == active_half_q - 1'b1) begin
            active_half_q <= pending_eff;
            count_q       <= '0;
            tone_q        <= ~tone_q;
         end else begin
            count_q <= count_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator. The DUT runs with CLK_HZ = 10 MHz so the tone
// intervals stay short; expected half-periods are floor(5_000_000 / freq):
//   440 Hz -> 11363, 9999 Hz -> 500, 1000 Hz -> 5000.
// Load latency is unchanged by CLK_HZ: 31 cycles through the divider,
// 5 cycles for a zero frequency, error on the cycle after the accept edge.
module tb_tone_generator;

   localparam int CLK_HZ = 10_000_000;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [3:0]  thousands_d, hundreds_d, tens_d, ones_d;
   logic        enable;
   logic        tone_out, busy, done, error;
   logic [13:0] freq_hz;

   typedef struct {
      bit is_err;
      int freq;
      int at_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   exp_t stim_e;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   localparam int EV_DONE = 0;
   localparam int EV_ERR  = 1;
   localparam int EV_NONE = 2;

   tone_generator #(.CLK_HZ(CLK_HZ)) dut (
      .clk            (clk),
      .reset          (reset),
      .load           (load),
      .Thousands_Data (thousands_d),
      .Hundreds_Data  (hundreds_d),
      .Tens_Data      (tens_d),
      .Ones_Data      (ones_d),
      .enable         (enable),
      .tone_out       (tone_out),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .freq_hz        (freq_hz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting at cycle %0d", name, cyc);
   endtask

   // Scoreboard monitor: every done/error pulse must match the oldest entry.
   always @(negedge clk) begin
      if (!reset && (done === 1'b1 || error === 1'b1)) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: done=%0b error=%0b freq_hz=%0d at cycle %0d, none expected",
                     done, error, freq_hz, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("event_kind_error", int'(error), int'(mon_e.is_err));
            check("event_cycle", cyc, mon_e.at_cyc);
            check("event_freq_hz", int'(freq_hz), mon_e.freq);
         end
      end
   end

   task automatic issue_load(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te,
                             input logic [3:0] o, input int kind, input int exp_freq,
                             input int latency);
      @(negedge clk);
      thousands_d = t;
      hundreds_d  = h;
      tens_d      = te;
      ones_d      = o;
      load        = 1'b1;
      if (kind != EV_NONE) begin
         stim_e.is_err = (kind == EV_ERR);
         stim_e.freq   = exp_freq;
         stim_e.at_cyc = cyc + 1 + latency;
         sb.push_back(stim_e);
      end
      @(negedge clk);
      load        = 1'b0;
      thousands_d = 4'hF;
      hundreds_d  = 4'hF;
      tens_d      = 4'hF;
      ones_d      = 4'hF;
   endtask

   task automatic wait_done(input string name, input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            at = cyc;
            return;
         end
      end
      timeout(name);
   endtask

   task automatic wait_toggle(input string name, input int bound, output int at);
      logic t0;
      t0 = tone_out;
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (tone_out !== t0) begin
            at = cyc;
            return;
         end
      end
      timeout(name);
   endtask

   task automatic count_high(input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tone_out !== 1'b0) hi++;
      end
   endtask

   initial begin
      int d, t1, t2, t3, t4, t5, s, hi, bz;
      reset       = 1'b1;
      load        = 1'b0;
      enable      = 1'b1;
      thousands_d = '0;
      hundreds_d  = '0;
      tens_d      = '0;
      ones_d      = '0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("reset_tone_out", int'(tone_out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_freq_hz", int'(freq_hz), 0);
      check("reset_done_error", int'({done, error}), 0);
      count_high(1000, hi);
      check("reset_silent_1000", hi, 0);

      // 440 Hz from silence: first toggle one full half-period after APPLY.
      issue_load(4'd0, 4'd4, 4'd4, 4'd0, EV_DONE, 440, 31);
      wait_done("done_440", 60, d);
      wait_toggle("toggle_440_a", 11500, t1);
      check("t440_first_half", t1 - d, 11363);
      wait_toggle("toggle_440_b", 11500, t2);
      check("t440_interval", t2 - t1, 11363);

      // 9999 Hz while running: the current 440 Hz half-period must complete.
      issue_load(4'd9, 4'd9, 4'd9, 4'd9, EV_DONE, 9999, 31);
      wait_done("done_9999", 60, d);
      wait_toggle("toggle_9999_a", 11500, t3);
      check("t9999_handover", t3 - t2, 11363);
      wait_toggle("toggle_9999_b", 600, t4);
      check("t9999_interval_1", t4 - t3, 500);
      wait_toggle("toggle_9999_c", 600, t5);
      check("t9999_interval_2", t5 - t4, 500);

      // Illegal digit: error pulse, FSM never leaves idle, frequency kept.
      issue_load(4'hA, 4'd0, 4'd0, 4'd1, EV_ERR, 9999, 0);
      bz = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy !== 1'b0) bz++;
      end
      check("error_busy_stays_low", bz, 0);
      check("error_freq_kept", int'(freq_hz), 9999);

      // Zero: no division, tone forced low at APPLY, then silence.
      issue_load(4'd0, 4'd0, 4'd0, 4'd0, EV_DONE, 0, 5);
      wait_done("done_zero", 20, d);
      check("zero_tone_low_at_apply", int'(tone_out), 0);
      count_high(600, hi);
      check("zero_silent", hi, 0);

      // Second load during DIVIDE must be ignored entirely.
      issue_load(4'd1, 4'd0, 4'd0, 4'd0, EV_DONE, 1000, 31);
      repeat (10) @(negedge clk);
      check("busy_during_divide", int'(busy), 1);
      issue_load(4'd2, 4'd0, 4'd0, 4'd0, EV_NONE, 0, 0);
      wait_done("done_1000", 60, d);
      wait_toggle("toggle_1000_a", 5100, t1);
      check("t1000_first_half", t1 - d, 5000);
      repeat (40) @(negedge clk);
      check("busy_reject_freq", int'(freq_hz), 1000);

      // Gate off: output held low; gate on: restart low from count 0.
      @(negedge clk);
      enable = 1'b0;
      count_high(50, hi);
      check("disabled_tone_low", hi, 0);
      @(negedge clk);
      enable = 1'b1;
      s = cyc;
      wait_toggle("toggle_reenable", 5100, t1);
      check("reenable_first_half", t1 - s, 5000);

      // Reset in the middle of DIVIDE: no done pulse, everything cleared.
      issue_load(4'd0, 4'd5, 4'd0, 4'd0, EV_NONE, 0, 0);
      repeat (12) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midreset_busy", int'(busy), 0);
      check("midreset_freq_hz", int'(freq_hz), 0);
      check("midreset_tone_out", int'(tone_out), 0);
      count_high(60, hi);
      check("midreset_silent", hi, 0);

      issue_load(4'd1, 4'd0, 4'd0, 4'd0, EV_DONE, 1000, 31);
      wait_done("done_after_reset", 60, d);
      wait_toggle("toggle_after_reset_a", 5100, t1);
      check("after_reset_first_half", t1 - d, 5000);
      wait_toggle("toggle_after_reset_b", 5100, t2);
      check("after_reset_interval", t2 - t1, 5000);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
